// File: rtl/multi_channel_scoreboard.sv
// Purpose : magic-packet scoreboard for NUM_CH independent FIFO-like channels;
//           captures one tagged packet per channel and checks it when popped.
// Latency : check result (data_out_vld/match) appears 1 cycle after the magic pop.
// Backpressure: none; passive observer, never stalls the monitored DUT.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start[i]           arm request, qualifies a capture together with push[i]
//   push[i], pop[i]    DUT push/pop strobes per channel
//   flat_data_in       DUT push data, channel i at [i*WIDTH +: WIDTH]
//   flat_data_out      DUT head data (show-ahead), same packing
//   data_out_vld[i]    1-cycle pulse: magic packet of channel i was checked
//   match[i]           check result, valid with data_out_vld[i]
//   busy[i]            channel i is tracking a captured packet
//   mismatch_err[i]    sticky failed check
//   proto_err[i]       sticky overflow/underflow of the DUT occupancy
//   prop_signal        registered, high while no mismatch_err bit is set
module multi_channel_scoreboard #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int REARM  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       push,
  input  logic [NUM_CH-1:0]       pop,
  input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
  input  logic [NUM_CH*WIDTH-1:0] flat_data_out,
  output logic [NUM_CH-1:0]       data_out_vld,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       mismatch_err,
  output logic [NUM_CH-1:0]       proto_err,
  output logic                    prop_signal
);

  localparam int CNTWID = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [NUM_CH-1:0] w_mm_next;
  logic              r_prop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t            r_state;
    state_t            w_state_next;
    logic [CNTWID-1:0] r_occ;
    logic [CNTWID-1:0] w_occ_next;
    logic [CNTWID-1:0] r_pos;
    logic [CNTWID-1:0] w_pos_next;
    logic [WIDTH-1:0]  r_cap;
    logic [WIDTH-1:0]  w_cap_next;
    logic [WIDTH-1:0]  w_din;
    logic [WIDTH-1:0]  w_dout;
    logic              w_full;
    logic              w_empty;
    logic              w_err;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_arm;
    logic              w_magic;
    logic              w_eq;
    logic              w_busy;
    logic              r_vld;
    logic              r_match;
    logic              r_mm;
    logic              r_perr;

    assign w_din   = flat_data_in[g*WIDTH +: WIDTH];
    assign w_dout  = flat_data_out[g*WIDTH +: WIDTH];
    assign w_full  = (r_occ == CNTWID'(DEPTH));
    assign w_empty = (r_occ == '0);

    // Any protocol violation freezes the whole channel for that cycle: occupancy
    // is held and neither the push nor the pop is treated as having happened.
    assign w_err     = (push[g] & w_full & ~pop[g]) | (pop[g] & w_empty);
    assign w_push_ok = push[g] & ~w_err;
    assign w_pop_ok  = pop[g] & ~w_err;
    assign w_occ_next = r_occ + CNTWID'(w_push_ok) - CNTWID'(w_pop_ok);

    assign w_arm   = start[g] & w_push_ok;
    assign w_magic = (r_state == S_TRACK) & w_pop_ok & (r_pos == CNTWID'(1));
    assign w_eq    = (w_dout == r_cap);

    // State register
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_pos   <= '0;
        r_cap   <= '0;
      end else begin
        r_state <= w_state_next;
        r_pos   <= w_pos_next;
        r_cap   <= w_cap_next;
      end
    end

    // Next-state logic. pos counts the pops still needed to reach the packet,
    // including the magic pop itself; a same-cycle pop is already ahead of it.
    always_comb begin
      w_state_next = r_state;
      w_pos_next   = r_pos;
      w_cap_next   = r_cap;
      case (r_state)
        S_IDLE: begin
          if (w_arm) begin
            w_state_next = S_TRACK;
            w_pos_next   = r_occ + CNTWID'(1) - CNTWID'(w_pop_ok);
            w_cap_next   = w_din;
          end
        end
        S_TRACK: begin
          if (w_magic) begin
            if ((REARM != 0) && w_arm) begin
              // Back-to-back capture: the magic pop leaves r_occ-1 entries
              // ahead of the new packet, plus the packet itself.
              w_state_next = S_TRACK;
              w_pos_next   = r_occ;
              w_cap_next   = w_din;
            end else begin
              w_state_next = (REARM != 0) ? S_IDLE : S_DONE;
            end
          end else if (w_pop_ok) begin
            w_pos_next = r_pos - CNTWID'(1);
          end
        end
        default: ;
      endcase
    end

    // Output logic
    always_comb begin
      w_busy = (r_state == S_TRACK);
    end

    assign w_mm_next[g] = r_mm | (w_magic & ~w_eq);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_occ   <= '0;
        r_vld   <= 1'b0;
        r_match <= 1'b0;
        r_mm    <= 1'b0;
        r_perr  <= 1'b0;
      end else begin
        r_occ   <= w_occ_next;
        r_vld   <= w_magic;
        r_match <= w_magic & w_eq;
        r_mm    <= w_mm_next[g];
        r_perr  <= r_perr | w_err;
      end
    end

    assign data_out_vld[g] = r_vld;
    assign match[g]        = r_match;
    assign busy[g]         = w_busy;
    assign mismatch_err[g] = r_mm;
    assign proto_err[g]    = r_perr;
  end

  // Computed from the next mismatch state so it drops together with mismatch_err.
  always_ff @(posedge clk) begin
    if (rst) r_prop <= 1'b1;
    else     r_prop <= ~|w_mm_next;
  end

  assign prop_signal = r_prop;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
module tb_multi_channel_scoreboard;

  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int W   = 8;

  logic            clk;
  logic            rst;
  logic [NCH-1:0]  start, push, pop;
  logic [NCH*W-1:0] flat_data_in, flat_data_out;
  logic [NCH-1:0]  vld0, mt0, bz0, mm0, pe0;
  logic [NCH-1:0]  vld1, mt1, bz1, mm1, pe1;
  logic            pr0, pr1;

  multi_channel_scoreboard #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .REARM(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .flat_data_out(flat_data_out),
    .data_out_vld(vld0), .match(mt0), .busy(bz0), .mismatch_err(mm0),
    .proto_err(pe0), .prop_signal(pr0)
  );

  multi_channel_scoreboard #(.NUM_CH(NCH), .DEPTH(DEP), .WIDTH(W), .REARM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop),
    .flat_data_in(flat_data_in), .flat_data_out(flat_data_out),
    .data_out_vld(vld1), .match(mt1), .busy(bz1), .mismatch_err(mm1),
    .proto_err(pe1), .prop_signal(pr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: each channel is a queue of pushed entries; a captured
  // packet is an entry flagged magic. Index 0 models REARM=0, index 1 REARM=1.
  typedef struct packed {
    logic [W-1:0] data;
    logic         magic;
  } ent_t;

  ent_t           q [2][NCH][$];
  logic           used [2][NCH];
  logic [NCH-1:0] e_vld [2];
  logic [NCH-1:0] e_mt  [2];
  logic [NCH-1:0] e_bz  [2];
  logic [NCH-1:0] e_mm  [2];
  logic [NCH-1:0] e_pe  [2];
  logic           e_pr  [2];

  always @(posedge clk) begin
    ent_t e;
    logic bad, hm;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        e_vld[d] = '0; e_mt[d] = '0; e_bz[d] = '0; e_mm[d] = '0; e_pe[d] = '0;
        e_pr[d]  = 1'b1;
        for (int c = 0; c < NCH; c++) begin
          q[d][c].delete();
          used[d][c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < NCH; c++) begin
          e_vld[d][c] = 1'b0;
          e_mt[d][c]  = 1'b0;
          bad = (push[c] && q[d][c].size() == DEP && !pop[c]) ||
                (pop[c] && q[d][c].size() == 0);
          if (bad) begin
            e_pe[d][c] = 1'b1;
          end else begin
            if (pop[c]) begin
              e = q[d][c].pop_front();
              if (e.magic) begin
                e_vld[d][c] = 1'b1;
                e_mt[d][c]  = (flat_data_out[c*W +: W] == e.data);
                if (!e_mt[d][c]) e_mm[d][c] = 1'b1;
              end
            end
            if (push[c]) begin
              hm = 1'b0;
              for (int k = 0; k < q[d][c].size(); k++) if (q[d][c][k].magic) hm = 1'b1;
              e.data  = flat_data_in[c*W +: W];
              e.magic = start[c] && ((d == 1) ? !hm : !used[d][c]);
              if (e.magic) used[d][c] = 1'b1;
              q[d][c].push_back(e);
            end
          end
          hm = 1'b0;
          for (int k = 0; k < q[d][c].size(); k++) if (q[d][c][k].magic) hm = 1'b1;
          e_bz[d][c] = hm;
        end
        e_pr[d] = ~|e_mm[d];
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("vld0", vld0, e_vld[0]);  chk("vld1", vld1, e_vld[1]);
      chk("match0", mt0, e_mt[0]);  chk("match1", mt1, e_mt[1]);
      chk("busy0", bz0, e_bz[0]);   chk("busy1", bz1, e_bz[1]);
      chk("mm0", mm0, e_mm[0]);     chk("mm1", mm1, e_mm[1]);
      chk("perr0", pe0, e_pe[0]);   chk("perr1", pe1, e_pe[1]);
      chk("prop0", pr0, e_pr[0]);   chk("prop1", pr1, e_pr[1]);
    end
  end

  // Drive one cycle; the head data presented is the true FIFO head xor cm.
  task automatic cyc(input logic [NCH-1:0] st, input logic [NCH-1:0] ps,
                     input logic [NCH-1:0] pp, input logic [NCH*W-1:0] din,
                     input logic [NCH*W-1:0] cm);
    logic [NCH*W-1:0] h;
    for (int c = 0; c < NCH; c++)
      h[c*W +: W] = (q[0][c].size() > 0) ? q[0][c][0].data : W'($urandom);
    start = st; push = ps; pop = pp;
    flat_data_in  = din;
    flat_data_out = h ^ cm;
    @(posedge clk); #1;
    start = '0; push = '0; pop = '0;
  endtask

  task automatic idle();
    cyc('0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = '0; push = '0; pop = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [NCH*W-1:0] at(input int c, input logic [W-1:0] v);
    logic [NCH*W-1:0] r;
    r = '0;
    r[c*W +: W] = v;
    return r;
  endfunction

  initial begin
    logic [NCH-1:0]   st, ps, pp;
    logic [NCH*W-1:0] din, cm;
    int occ, pprob;

    rst = 1'b1; start = '0; push = '0; pop = '0;
    flat_data_in = '0; flat_data_out = '0;
    do_reset();
    chk_on = 1'b1;
    chk("rst_vld", vld0, 4'h0); chk("rst_busy", bz0 | bz1, 4'h0);
    chk("rst_perr", pe0, 4'h0); chk("rst_prop", {pr0, pr1}, 2'b11);

    // Matching check on ch0
    cyc(4'h0, 4'h1, 4'h0, at(0, 8'h11), '0);
    cyc(4'h0, 4'h1, 4'h0, at(0, 8'h22), '0);
    cyc(4'h1, 4'h1, 4'h0, at(0, 8'h33), '0);
    chk("t1_busy", bz0, 4'h1);
    cyc(4'h0, 4'h0, 4'h1, '0, '0);
    cyc(4'h0, 4'h0, 4'h1, '0, '0);
    chk("t1_novld", vld0, 4'h0);
    cyc(4'h0, 4'h0, 4'h1, '0, '0);
    chk("t1_vld", vld0, 4'h1); chk("t1_match", mt0, 4'h1); chk("t1_prop", pr0, 1'b1);
    idle();
    chk("t1_pulse", vld0, 4'h0); chk("t1_done", bz0, 4'h0);

    // Mismatching check on ch0 (head 0x33 presented as 0x34)
    do_reset();
    cyc(4'h0, 4'h1, 4'h0, at(0, 8'h11), '0);
    cyc(4'h0, 4'h1, 4'h0, at(0, 8'h22), '0);
    cyc(4'h1, 4'h1, 4'h0, at(0, 8'h33), '0);
    cyc(4'h0, 4'h0, 4'h1, '0, '0);
    cyc(4'h0, 4'h0, 4'h1, '0, '0);
    cyc(4'h0, 4'h0, 4'h1, '0, at(0, 8'h07));
    chk("t2_vld", vld0, 4'h1); chk("t2_match", mt0, 4'h0);
    chk("t2_mm", mm0, 4'h1);   chk("t2_prop", pr0, 1'b0);
    idle(); idle();
    chk("t2_prop_sticky", pr0, 1'b0); chk("t2_mm_sticky", mm0, 4'h1);

    // ch2 capture with a simultaneous pop: two further pops reach the packet
    do_reset();
    cyc(4'h0, 4'h4, 4'h0, at(2, 8'h10), '0);
    cyc(4'h0, 4'h4, 4'h0, at(2, 8'h20), '0);
    cyc(4'h4, 4'h4, 4'h4, at(2, 8'hA5), '0);
    cyc(4'h0, 4'h0, 4'h4, '0, '0);
    chk("t3_novld", vld0, 4'h0); chk("t3_busy", bz0, 4'h4);
    cyc(4'h0, 4'h0, 4'h4, '0, '0);
    chk("t3_vld", vld0, 4'h4); chk("t3_match", mt0, 4'h4);

    // ch1 back-to-back capture in the REARM=1 instance
    do_reset();
    cyc(4'h0, 4'h2, 4'h0, at(1, 8'h01), '0);
    cyc(4'h0, 4'h2, 4'h0, at(1, 8'h02), '0);
    cyc(4'h2, 4'h2, 4'h0, at(1, 8'h77), '0);
    cyc(4'h0, 4'h0, 4'h2, '0, '0);
    cyc(4'h0, 4'h0, 4'h2, '0, '0);
    cyc(4'h0, 4'h2, 4'h0, at(1, 8'h03), '0);
    cyc(4'h2, 4'h2, 4'h2, at(1, 8'h5A), '0);
    chk("t4_vld1", vld1, 4'h2); chk("t4_match1", mt1, 4'h2);
    chk("t4_busy1", bz1, 4'h2); chk("t4_busy0", bz0, 4'h0);
    cyc(4'h0, 4'h0, 4'h2, '0, '0);
    chk("t4_novld", vld1, 4'h0);
    cyc(4'h0, 4'h0, 4'h2, '0, '0);
    chk("t4_vld1b", vld1, 4'h2); chk("t4_match1b", mt1, 4'h2); chk("t4_vld0b", vld0, 4'h0);

    // ch3 underflow, full push+pop, overflow
    do_reset();
    cyc(4'h0, 4'h0, 4'h8, '0, '0);
    chk("t5_underflow", pe0, 4'h8);
    do_reset();
    for (int i = 0; i < DEP; i++) cyc(4'h0, 4'h8, 4'h0, at(3, 8'(i)), '0);
    chk("t5_full_ok", pe0, 4'h0);
    cyc(4'h0, 4'h8, 4'h8, at(3, 8'hEE), '0);
    chk("t5_pushpop_full", pe0, 4'h0);
    cyc(4'h0, 4'h8, 4'h0, at(3, 8'hEF), '0);
    chk("t5_overflow", pe0, 4'h8);
    for (int i = 0; i < DEP + 1; i++) cyc(4'h0, 4'h0, 4'h8, '0, '0);

    // Reset while ch0 is tracking with pos=4
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'h0, 4'h1, 4'h0, at(0, 8'(8'h40 + i)), '0);
    cyc(4'h1, 4'h1, 4'h0, at(0, 8'h99), '0);
    chk("t6_busy", bz0, 4'h1);
    do_reset();
    chk("t6_vld", vld0, 4'h0); chk("t6_busy_rst", bz0, 4'h0); chk("t6_prop", pr0, 1'b1);
    idle(); idle(); idle();

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      do_reset();
      pprob = 35 + r * 4;
      for (int n = 0; n < 400; n++) begin
        cm = '0;
        for (int c = 0; c < NCH; c++) begin
          occ   = q[0][c].size();
          pp[c] = ($urandom_range(0, 99) < 45) && (occ > 0 || $urandom_range(0, 49) == 0);
          ps[c] = ($urandom_range(0, 99) < pprob) &&
                  (occ < DEP || pp[c] || $urandom_range(0, 49) == 0);
          st[c] = ($urandom_range(0, 99) < 25);
          din[c*W +: W] = W'($urandom);
          if ($urandom_range(0, 99) < 3) cm[c*W +: W] = W'($urandom_range(1, 255));
        end
        cyc(st, ps, pp, din, cm);
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
